// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / debug-loader) arbiter in front of a single-port data memory.
// Ties go to the CPU by default; define DMEM_ARB_ROUND_ROBIN_EN to alternate on ties.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {WIN_CPU = 1'b0, WIN_DBG = 1'b1} win_t;

  state_t state_q, state_d;
  win_t   last_q, last_d;
  win_t   win;
  logic   we_q, we_d;

  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              cpu_gnt_d, dbg_gnt_d, cpu_rvalid_d, dbg_rvalid_d;

  // Winner selection; a lone requester always wins
  always_comb begin
    if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      win = (last_q == WIN_DBG) ? WIN_CPU : WIN_DBG;
`else
      win = WIN_CPU;
`endif
    end else begin
      win = dbg_req ? WIN_DBG : WIN_CPU;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    we_d         = we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (cpu_req || dbg_req) begin
          state_d     = ACCESS;
          last_d      = win;
          mem_en_d    = 1'b1;
          mem_we_d    = (win == WIN_DBG) ? dbg_we    : cpu_we;
          mem_addr_d  = (win == WIN_DBG) ? dbg_addr  : cpu_addr;
          mem_wdata_d = (win == WIN_DBG) ? dbg_wdata : cpu_wdata;
          we_d        = mem_we_d;
          cpu_gnt_d   = (win == WIN_CPU);
          dbg_gnt_d   = (win == WIN_DBG);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Requests are ignored here; last_q names the requester being served
        state_d      = RESP;
        cpu_rvalid_d = (last_q == WIN_CPU);
        dbg_rvalid_d = (last_q == WIN_DBG);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= WIN_DBG;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      we_q       <= we_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_gnt    <= cpu_gnt_d;
      dbg_gnt    <= dbg_gnt_d;
      cpu_rvalid <= cpu_rvalid_d;
      dbg_rvalid <= dbg_rvalid_d;
    end
  end

  // Memory read data arrives in the RESP cycle itself, so rdata is steered, not registered
  assign cpu_rdata = (cpu_rvalid && !we_q) ? mem_rdata : '0;
  assign dbg_rdata = (dbg_rvalid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous memory model.
// Tie expectations follow DMEM_ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
  logic              cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [0:63];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word i holds i*5 after reset; read data one cycle after mem_en
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 5);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  wire [133:0] outs = {cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
                       mem_en, mem_we, mem_addr, mem_wdata};

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  logic exp_cpu;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outs", outs, 0);
    rst = 1'b0;
    tick();
    chk("idle_outs", outs, 0);

    // Single CPU read of word[1]
    cpu_req = 1'b1; cpu_addr = 32'h4;
    tick();
    chk("rd_cpu_gnt", cpu_gnt, 1);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 32'h4);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_dbg_gnt", dbg_gnt, 0);
    idle_inputs();
    tick();
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_rdata", cpu_rdata, 32'h5);
    chk("rd_cpu_gnt_off", cpu_gnt, 0);
    chk("rd_mem_en_off", mem_en, 0);
    chk("rd_dbg_quiet", {dbg_gnt, dbg_rvalid, dbg_rdata}, 0);
    tick();
    chk("rd_back_idle", outs, 0);

    // Debug write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hAD09_0000;
    tick();
    chk("wr_dbg_gnt", dbg_gnt, 1);
    chk("wr_cpu_gnt", cpu_gnt, 0);
    chk("wr_mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h10, 32'hAD09_0000});
    idle_inputs();
    tick();
    chk("wr_dbg_rvalid", dbg_rvalid, 1);
    chk("wr_dbg_rdata", dbg_rdata, 0);
    chk("wr_mem_word", mem[4], 32'hAD09_0000);
    tick();
    chk("wr_back_idle", outs, 0);

    // Tie: last winner is DBG, both hold req for four accesses
    cpu_req = 1'b1; cpu_addr = 32'h8;
    dbg_req = 1'b1; dbg_addr = 32'hC;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_cpu = (i % 2 == 0);
`else
      exp_cpu = 1'b1;
`endif
      if (i == 3) begin
        tick();
        idle_inputs();
      end else begin
        tick();
      end
      chk($sformatf("tie_gnt%0d", i), {cpu_gnt, dbg_gnt}, {exp_cpu, !exp_cpu});
      chk($sformatf("tie_addr%0d", i), mem_addr, exp_cpu ? 32'h8 : 32'hC);
      tick();
      chk($sformatf("tie_rv%0d", i), {cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt},
          {exp_cpu, !exp_cpu, 2'b00});
      chk($sformatf("tie_rdata%0d", i), exp_cpu ? cpu_rdata : dbg_rdata,
          exp_cpu ? 32'd10 : 32'd15);
    end
    tick();
    chk("tie_back_idle", outs, 0);

    // Back-to-back: DBG presented in the CPU's RESP cycle
    cpu_req = 1'b1; cpu_addr = 32'h8;
    tick();
    chk("b2b_cpu_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
    idle_inputs();
    dbg_req = 1'b1; dbg_addr = 32'h4;
    tick();
    chk("b2b_cpu_rv", {cpu_rvalid, cpu_rdata, dbg_gnt}, {1'b1, 32'd10, 1'b0});
    tick();
    chk("b2b_dbg_gnt", {dbg_gnt, cpu_gnt, mem_en, mem_addr}, {3'b101, 32'h4});
    idle_inputs();
    tick();
    chk("b2b_dbg_rv", {dbg_rvalid, dbg_rdata, cpu_rvalid}, {1'b1, 32'd5, 1'b0});
    tick();
    chk("b2b_back_idle", outs, 0);

    // Reset in the ACCESS cycle of a CPU read
    cpu_req = 1'b1; cpu_addr = 32'h4;
    tick();
    chk("rst_cpu_gnt", cpu_gnt, 1);
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("rst_outs", outs, 0);
    rst = 1'b0;
    tick();
    chk("rst_no_rvalid", outs, 0);
    cpu_req = 1'b1; cpu_addr = 32'h4;
    dbg_req = 1'b1; dbg_addr = 32'h8;
    tick();
    chk("rst_tie_gnt", {cpu_gnt, dbg_gnt, mem_addr}, {2'b10, 32'h4});
    idle_inputs();
    tick();
    chk("rst_tie_rv", {cpu_rvalid, cpu_rdata, dbg_rvalid}, {1'b1, 32'd5, 1'b0});
    tick();
    chk("final_idle", outs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
